l1d_mshr_file: RTL and testbench
================================

Name: l1d_mshr_file

Overview:
- Miss status holding register file sitting directly downstream of l1_data_cache, between the L1D and the next cache level.
- Accepts primary and secondary misses from the L1D, merges same-block misses, and issues one block fetch per entry to the lower level.
- On fill, replays the merged targets as completions in order, then hands the store-merged block back to the L1D for installation.

Parameters:
- MSHR_COUNT, 4, number of entries.
- TARGETS, 4, max merged requests per entry.
- B, 64, block size in bytes.
- PADDR_BITS, 19, physical address width.
- TAG_BITS, 10, request tag width.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- miss_valid_in  in  1  L1D miss request valid.
- miss_ready_out  out  1  miss accepted this cycle when high with valid.
- miss_addr_in  in  PADDR_BITS  miss address; 8-byte aligned, bits [2:0] ignored.
- miss_we_in  in  1  1 = store, 0 = load.
- miss_value_in  in  64  store data.
- miss_tag_in  in  TAG_BITS  request tag.
- lc_req_valid_out  out  1  block fetch valid.
- lc_req_ready_in  in  1  lower level accepts fetch.
- lc_req_addr_out  out  PADDR_BITS  block-aligned fetch address.
- lc_resp_valid_in  in  1  fill data valid; always accepted.
- lc_resp_addr_in  in  PADDR_BITS  block address of fill.
- lc_resp_data_in  in  B*8  fill block.
- cmpl_valid_out  out  1  target completion valid; no backpressure.
- cmpl_tag_out  out  TAG_BITS  completed tag.
- cmpl_we_out  out  1  completed request was a store.
- cmpl_value_out  out  64  load data, or store data for stores.
- fill_valid_out  out  1  merged block ready for L1D install.
- fill_ready_in  in  1  L1D accepts install.
- fill_addr_out  out  PADDR_BITS  block-aligned address.
- fill_data_out  out  B*8  block with all stores merged.

Behaviour:
- Reset:
  - All entries go to FREE; target counts cleared.
  - All valid outputs are 0; miss_ready_out is 0 during reset.
  - All data and address outputs are 0.
  - Reset mid-operation discards all entries and in-flight drains; late fills arriving after reset are ignored.
- Entry states: FREE, ISSUE, WAIT, READY, DRAIN.
- Miss acceptance (miss_ready_out is combinational from miss_addr_in and state):
  - Block match with an entry in ISSUE/WAIT/READY and count < TARGETS: append target at index count. Ready = 1.
  - Block match with a full entry, or with an entry in DRAIN: ready = 0 (stall).
  - No match and a FREE entry exists: allocate the lowest-index FREE entry as target 0, state ISSUE. Ready = 1.
  - No match and no FREE entry: ready = 0.
  - An entry freed in cycle N is allocatable from cycle N+1.
  - miss_valid_in must not depend on miss_ready_out.
- Issue (ISSUE→WAIT):
  - The lowest-index ISSUE entry drives lc_req_valid_out with addr & ~(B-1).
  - Valid and addr are held stable until lc_req_ready_in.
  - The handshake moves the entry to WAIT. One outstanding fetch per entry.
- Fill (WAIT→READY):
  - lc_resp_valid_in whose block address matches a WAIT entry captures the data and moves that entry to READY.
  - A non-matching response is dropped.
  - A merge and a fill to the same entry in the same cycle are both honoured.
- Drain engine, one entry at a time, lowest-index READY entry first:
  - The entry enters DRAIN.
  - One completion per cycle, targets 0..count-1 in order.
  - A store writes miss_value_in into word addr[log2(B)-1:3] of the working block, then completes.
  - A load returns the word reflecting only earlier targets.
  - After the last target, fill_valid_out is held with the final block until fill_ready_in.
  - The entry then returns to FREE.
  - Minimum latency: fill capture to first cmpl_valid_out = 2 cycles.
- Arithmetic:
  - Block address = addr >> log2(B).
  - Word index = addr[log2(B)-1:3].
  - Target count width = $clog2(TARGETS+1).

Optional Feature:
- MSHR_STATS_EN defined:
  - Three 32-bit saturating counters, cleared on reset: primary allocations, secondary merges, stall cycles (valid && !ready).
  - Exposed on stat_primary_out, stat_merge_out, stat_stall_out.
- Undefined: those ports and the counters are absent.

Decomposition:
- l1d_mshr_pkg:
  - mshr_state_e enum.
  - mshr_target_t struct {tag, we, word_idx, value}.
  - mshr_entry_t struct {state, blk_addr, count}.
  - Helper functions blk_of() and word_of().
- Sub-module mshr_prio_enc: parameterised lowest-set-bit encoder, used for free allocation, issue select and drain select.

Test Plan:
- Load 0x01040 tag 5 → lc_req_addr 0x01040; fill with word 0 = 0xAA → cmpl tag 5, value 0xAA; fill_valid_out with addr 0x01040.
- Load 0x2000 tag 1, store 0x2008 value 0x55 tag 2, load 0x2008 tag 3, all before fill → one lc request; completions in order 1, 2, 3; tag 3 returns 0x55; fill block word1 = 0x55.
- 4 distinct-block misses fill all entries; 5th miss → miss_ready_out = 0 until the first entry frees, then it allocates entry 0.
- 5 merges to one block with TARGETS = 4 → 5th stalls; after drain and free it allocates a new entry.
- Hold lc_req_ready_in = 0 for 10 cycles → lc_req_valid/addr stable; assert ready → entry moves to WAIT next cycle.
- Assert rst_in while DRAIN is mid-target with fill_ready_in = 0 → next cycle all valid outputs are 0; a late fill response is ignored.

Source files
------------

// File: rtl/l1d_mshr_pkg.sv
// Shared types, sizes and address helpers for the L1D miss status holding register file.
package l1d_mshr_pkg;

   localparam int MSHR_COUNT = 4;
   localparam int TARGETS    = 4;
   localparam int B          = 64;
   localparam int PADDR_BITS = 19;
   localparam int TAG_BITS   = 10;

   localparam int BLK_W     = B * 8;
   localparam int OFF_BITS  = $clog2(B);
   localparam int BLK_BITS  = PADDR_BITS - OFF_BITS;
   localparam int WIDX_BITS = OFF_BITS - 3;
   localparam int CNT_BITS  = $clog2(TARGETS + 1);
   localparam int TGT_BITS  = $clog2(TARGETS);
   localparam int ENT_BITS  = $clog2(MSHR_COUNT);

   typedef enum logic [2:0] {
      ST_FREE,
      ST_ISSUE,
      ST_WAIT,
      ST_READY,
      ST_DRAIN
   } mshr_state_e;

   typedef struct packed {
      logic [TAG_BITS-1:0]  tag;
      logic                 we;
      logic [WIDX_BITS-1:0] word_idx;
      logic [63:0]          value;
   } mshr_target_t;

   typedef struct packed {
      mshr_state_e         state;
      logic [BLK_BITS-1:0] blk_addr;
      logic [CNT_BITS-1:0] count;
   } mshr_entry_t;

   function automatic logic [BLK_BITS-1:0] blk_of(input logic [PADDR_BITS-1:0] a);
      return BLK_BITS'(a >> OFF_BITS);
   endfunction

   function automatic logic [WIDX_BITS-1:0] word_of(input logic [PADDR_BITS-1:0] a);
      return WIDX_BITS'(a >> 3);
   endfunction

endpackage

// File: rtl/l1d_mshr_prio_enc.sv
// Lowest-set-bit encoder shared by free-entry allocation, issue select and drain select.
module mshr_prio_enc #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] i_req,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   always_comb begin
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) o_idx = W'(i);
      end
      o_any = |i_req;
   end

endmodule

// File: rtl/l1d_mshr_file.sv
// MSHR file between L1D and the next level: merges same-block misses, fetches, replays targets, returns merged block.
// Optional MSHR_STATS_EN adds saturating primary/merge/stall counters.
//
// Entry state | meaning
// FREE        | unused, allocatable
// ISSUE       | waiting to send block fetch
// WAIT        | fetch sent, waiting for fill
// READY       | fill captured, waiting for drain engine
// DRAIN       | owned by drain engine until L1D accepts install
//
// Drain state | meaning
// DR_IDLE     | no entry draining
// DR_TGT      | replaying one target per cycle
// DR_FILL     | holding merged block until fill_ready_in
module l1d_mshr_file
   import l1d_mshr_pkg::*;
(
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  miss_valid_in,
   output logic                  miss_ready_out,
   input  logic [PADDR_BITS-1:0] miss_addr_in,
   input  logic                  miss_we_in,
   input  logic [63:0]           miss_value_in,
   input  logic [TAG_BITS-1:0]   miss_tag_in,
   output logic                  lc_req_valid_out,
   input  logic                  lc_req_ready_in,
   output logic [PADDR_BITS-1:0] lc_req_addr_out,
   input  logic                  lc_resp_valid_in,
   input  logic [PADDR_BITS-1:0] lc_resp_addr_in,
   input  logic [BLK_W-1:0]      lc_resp_data_in,
   output logic                  cmpl_valid_out,
   output logic [TAG_BITS-1:0]   cmpl_tag_out,
   output logic                  cmpl_we_out,
   output logic [63:0]           cmpl_value_out,
   output logic                  fill_valid_out,
   input  logic                  fill_ready_in,
   output logic [PADDR_BITS-1:0] fill_addr_out,
`ifdef MSHR_STATS_EN
   output logic [31:0]           stat_primary_out,
   output logic [31:0]           stat_merge_out,
   output logic [31:0]           stat_stall_out,
`endif
   output logic [BLK_W-1:0]      fill_data_out
);

   typedef enum logic [1:0] {
      DR_IDLE,
      DR_TGT,
      DR_FILL
   } drain_state_e;

   mshr_entry_t  r_ent [MSHR_COUNT];
   mshr_target_t r_tgt [MSHR_COUNT][TARGETS];
   logic [BLK_W-1:0] r_blk [MSHR_COUNT];

   logic [MSHR_COUNT-1:0] w_hit_vec, w_free_vec, w_issue_vec, w_rdy_vec, w_resp_vec;
   logic [ENT_BITS-1:0]   w_hit_idx, w_free_idx, w_issue_idx, w_rdy_idx, w_iss_idx;
   logic                  w_hit_any, w_free_any, w_issue_any, w_rdy_any;
   logic [BLK_BITS-1:0]   w_miss_blk, w_resp_blk;
   logic                  w_can_merge, w_do_merge, w_do_alloc, w_iss_fire;
   mshr_target_t          w_new_tgt, w_cur_tgt;
   logic [63:0]           w_cur_word;
   logic                  w_dr_last, w_drain_start, w_drain_done;
   drain_state_e          w_dr_next;

   logic                  r_iss_hold;
   logic [ENT_BITS-1:0]   r_iss_idx;
   drain_state_e          r_dr_state;
   logic [ENT_BITS-1:0]   r_dr_ent;
   logic [CNT_BITS-1:0]   r_dr_tgt;
   logic [BLK_W-1:0]      r_work;
   logic                  r_cmpl_valid, r_cmpl_we;
   logic [TAG_BITS-1:0]   r_cmpl_tag;
   logic [63:0]           r_cmpl_value;

   always_comb begin
      w_miss_blk  = blk_of(miss_addr_in);
      w_resp_blk  = blk_of(lc_resp_addr_in);
      w_hit_vec   = '0;
      w_free_vec  = '0;
      w_issue_vec = '0;
      w_rdy_vec   = '0;
      w_resp_vec  = '0;
      for (int i = 0; i < MSHR_COUNT; i++) begin
         w_hit_vec[i]   = (r_ent[i].state != ST_FREE) && (r_ent[i].blk_addr == w_miss_blk);
         w_free_vec[i]  = (r_ent[i].state == ST_FREE);
         w_issue_vec[i] = (r_ent[i].state == ST_ISSUE);
         w_rdy_vec[i]   = (r_ent[i].state == ST_READY);
         w_resp_vec[i]  = lc_resp_valid_in && (r_ent[i].state == ST_WAIT)
                          && (r_ent[i].blk_addr == w_resp_blk);
      end
   end

   mshr_prio_enc #(.N(MSHR_COUNT), .W(ENT_BITS)) u_hit_enc (
      .i_req(w_hit_vec), .o_idx(w_hit_idx), .o_any(w_hit_any));
   mshr_prio_enc #(.N(MSHR_COUNT), .W(ENT_BITS)) u_free_enc (
      .i_req(w_free_vec), .o_idx(w_free_idx), .o_any(w_free_any));
   mshr_prio_enc #(.N(MSHR_COUNT), .W(ENT_BITS)) u_issue_enc (
      .i_req(w_issue_vec), .o_idx(w_issue_idx), .o_any(w_issue_any));
   mshr_prio_enc #(.N(MSHR_COUNT), .W(ENT_BITS)) u_rdy_enc (
      .i_req(w_rdy_vec), .o_idx(w_rdy_idx), .o_any(w_rdy_any));

   // A DRAIN entry still owns its block address, so a same-block miss must stall rather than allocate.
   assign w_can_merge = (r_ent[w_hit_idx].state inside {ST_ISSUE, ST_WAIT, ST_READY})
                        && (r_ent[w_hit_idx].count < CNT_BITS'(TARGETS));
   assign miss_ready_out = !rst_in && (w_hit_any ? w_can_merge : w_free_any);
   assign w_do_merge     = miss_valid_in && miss_ready_out && w_hit_any;
   assign w_do_alloc     = miss_valid_in && miss_ready_out && !w_hit_any;

   always_comb begin
      w_new_tgt          = '0;
      w_new_tgt.tag      = miss_tag_in;
      w_new_tgt.we       = miss_we_in;
      w_new_tgt.word_idx = word_of(miss_addr_in);
      w_new_tgt.value    = miss_value_in;
   end

   // Lock the selected entry while stalled so a newly allocated lower index cannot change the request.
   assign w_iss_idx        = r_iss_hold ? r_iss_idx : w_issue_idx;
   assign lc_req_valid_out = !rst_in && (r_iss_hold || w_issue_any);
   assign lc_req_addr_out  = lc_req_valid_out ? {r_ent[w_iss_idx].blk_addr, OFF_BITS'(0)} : '0;
   assign w_iss_fire       = lc_req_valid_out && lc_req_ready_in;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_iss_hold <= 1'b0;
         r_iss_idx  <= '0;
      end else begin
         r_iss_hold <= lc_req_valid_out && !lc_req_ready_in;
         r_iss_idx  <= w_iss_idx;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < MSHR_COUNT; i++) begin
            r_ent[i].state    <= ST_FREE;
            r_ent[i].blk_addr <= '0;
            r_ent[i].count    <= '0;
         end
      end else begin
         for (int i = 0; i < MSHR_COUNT; i++) begin
            case (r_ent[i].state)
               ST_FREE: begin
                  if (w_do_alloc && w_free_idx == ENT_BITS'(i)) begin
                     r_ent[i].state    <= ST_ISSUE;
                     r_ent[i].blk_addr <= w_miss_blk;
                     r_ent[i].count    <= CNT_BITS'(1);
                  end
               end
               ST_ISSUE: if (w_iss_fire && w_iss_idx == ENT_BITS'(i)) r_ent[i].state <= ST_WAIT;
               ST_WAIT:  if (w_resp_vec[i]) r_ent[i].state <= ST_READY;
               ST_READY: if (w_drain_start && w_rdy_idx == ENT_BITS'(i)) r_ent[i].state <= ST_DRAIN;
               ST_DRAIN: begin
                  if (w_drain_done && r_dr_ent == ENT_BITS'(i)) begin
                     r_ent[i].state <= ST_FREE;
                     r_ent[i].count <= '0;
                  end
               end
               default: r_ent[i].state <= ST_FREE;
            endcase
            if (w_do_merge && w_hit_idx == ENT_BITS'(i)) r_ent[i].count <= r_ent[i].count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      for (int i = 0; i < MSHR_COUNT; i++) begin
         if (w_do_alloc && w_free_idx == ENT_BITS'(i)) r_tgt[i][0] <= w_new_tgt;
         if (w_do_merge && w_hit_idx == ENT_BITS'(i))
            r_tgt[i][r_ent[i].count[TGT_BITS-1:0]] <= w_new_tgt;
         if (w_resp_vec[i]) r_blk[i] <= lc_resp_data_in;
      end
   end

   assign w_cur_tgt  = r_tgt[r_dr_ent][r_dr_tgt[TGT_BITS-1:0]];
   assign w_cur_word = r_work[{w_cur_tgt.word_idx, 6'd0} +: 64];
   assign w_dr_last  = (r_dr_tgt + 1'b1) == r_ent[r_dr_ent].count;

   always_comb begin
      w_dr_next     = r_dr_state;
      w_drain_start = 1'b0;
      w_drain_done  = 1'b0;
      case (r_dr_state)
         DR_IDLE: begin
            if (w_rdy_any) begin
               w_drain_start = 1'b1;
               w_dr_next     = DR_TGT;
            end
         end
         DR_TGT: if (w_dr_last) w_dr_next = DR_FILL;
         DR_FILL: begin
            if (fill_ready_in) begin
               w_drain_done = 1'b1;
               w_dr_next    = DR_IDLE;
            end
         end
         default: w_dr_next = DR_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_dr_state   <= DR_IDLE;
         r_dr_ent     <= '0;
         r_dr_tgt     <= '0;
         r_work       <= '0;
         r_cmpl_valid <= 1'b0;
         r_cmpl_we    <= 1'b0;
         r_cmpl_tag   <= '0;
         r_cmpl_value <= '0;
      end else begin
         r_dr_state   <= w_dr_next;
         r_cmpl_valid <= 1'b0;
         r_cmpl_we    <= 1'b0;
         r_cmpl_tag   <= '0;
         r_cmpl_value <= '0;
         if (w_drain_start) begin
            r_dr_ent <= w_rdy_idx;
            r_dr_tgt <= '0;
            r_work   <= r_blk[w_rdy_idx];
         end
         // Loads read the working block, so they see only stores replayed before them.
         if (r_dr_state == DR_TGT) begin
            r_cmpl_valid <= 1'b1;
            r_cmpl_we    <= w_cur_tgt.we;
            r_cmpl_tag   <= w_cur_tgt.tag;
            r_cmpl_value <= w_cur_tgt.we ? w_cur_tgt.value : w_cur_word;
            if (w_cur_tgt.we) r_work[{w_cur_tgt.word_idx, 6'd0} +: 64] <= w_cur_tgt.value;
            r_dr_tgt <= r_dr_tgt + 1'b1;
         end
      end
   end

   assign cmpl_valid_out = r_cmpl_valid && !rst_in;
   assign cmpl_tag_out   = r_cmpl_tag;
   assign cmpl_we_out    = r_cmpl_we;
   assign cmpl_value_out = r_cmpl_value;
   assign fill_valid_out = !rst_in && (r_dr_state == DR_FILL);
   assign fill_addr_out  = fill_valid_out ? {r_ent[r_dr_ent].blk_addr, OFF_BITS'(0)} : '0;
   assign fill_data_out  = fill_valid_out ? r_work : '0;

`ifdef MSHR_STATS_EN
   logic [31:0] r_stat_prim, r_stat_merge, r_stat_stall;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_stat_prim  <= '0;
         r_stat_merge <= '0;
         r_stat_stall <= '0;
      end else begin
         if (w_do_alloc && r_stat_prim != '1) r_stat_prim <= r_stat_prim + 1'b1;
         if (w_do_merge && r_stat_merge != '1) r_stat_merge <= r_stat_merge + 1'b1;
         if (miss_valid_in && !miss_ready_out && r_stat_stall != '1)
            r_stat_stall <= r_stat_stall + 1'b1;
      end
   end

   assign stat_primary_out = r_stat_prim;
   assign stat_merge_out   = r_stat_merge;
   assign stat_stall_out   = r_stat_stall;
`endif

endmodule

// File: tb/tb_l1d_mshr_file.sv
// Directed bench for l1d_mshr_file: allocation, merging, issue hold, drain order and latency, reset.
module tb_l1d_mshr_file;

   logic         clk_in = 1'b0;
   logic         rst_in;
   logic         miss_valid_in, miss_ready_out, miss_we_in;
   logic [18:0]  miss_addr_in;
   logic [63:0]  miss_value_in;
   logic [9:0]   miss_tag_in;
   logic         lc_req_valid_out, lc_req_ready_in;
   logic [18:0]  lc_req_addr_out;
   logic         lc_resp_valid_in;
   logic [18:0]  lc_resp_addr_in;
   logic [511:0] lc_resp_data_in;
   logic         cmpl_valid_out, cmpl_we_out;
   logic [9:0]   cmpl_tag_out;
   logic [63:0]  cmpl_value_out;
   logic         fill_valid_out, fill_ready_in;
   logic [18:0]  fill_addr_out;
   logic [511:0] fill_data_out;

   int n_checks = 0;
   int n_fail   = 0;
   int n_cmpl   = 0;

   always #5 clk_in = ~clk_in;

   l1d_mshr_file dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .miss_valid_in(miss_valid_in), .miss_ready_out(miss_ready_out),
      .miss_addr_in(miss_addr_in), .miss_we_in(miss_we_in),
      .miss_value_in(miss_value_in), .miss_tag_in(miss_tag_in),
      .lc_req_valid_out(lc_req_valid_out), .lc_req_ready_in(lc_req_ready_in),
      .lc_req_addr_out(lc_req_addr_out),
      .lc_resp_valid_in(lc_resp_valid_in), .lc_resp_addr_in(lc_resp_addr_in),
      .lc_resp_data_in(lc_resp_data_in),
      .cmpl_valid_out(cmpl_valid_out), .cmpl_tag_out(cmpl_tag_out),
      .cmpl_we_out(cmpl_we_out), .cmpl_value_out(cmpl_value_out),
      .fill_valid_out(fill_valid_out), .fill_ready_in(fill_ready_in),
      .fill_addr_out(fill_addr_out), .fill_data_out(fill_data_out)
   );

   always @(negedge clk_in) if (cmpl_valid_out) n_cmpl++;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic send_miss(input logic [18:0] a, input logic we, input logic [63:0] v,
                            input logic [9:0] t);
      miss_valid_in = 1'b1;
      miss_addr_in  = a;
      miss_we_in    = we;
      miss_value_in = v;
      miss_tag_in   = t;
      #1;
      chk("miss_rdy", miss_ready_out, 1);
      tick();
      miss_valid_in = 1'b0;
   endtask

   task automatic send_fill(input logic [18:0] a, input logic [511:0] d);
      lc_resp_valid_in = 1'b1;
      lc_resp_addr_in  = a;
      lc_resp_data_in  = d;
      tick();
      lc_resp_valid_in = 1'b0;
   endtask

   task automatic exp_cmpl(input string tag, input logic we, input logic [9:0] t,
                           input logic [63:0] v);
      chk(tag, {cmpl_valid_out, cmpl_we_out, cmpl_tag_out, cmpl_value_out}, {1'b1, we, t, v});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [511:0] d;
      int n0;

      rst_in = 1'b1;
      miss_valid_in = 1'b0; miss_addr_in = '0; miss_we_in = 1'b0;
      miss_value_in = '0;   miss_tag_in = '0;
      lc_req_ready_in = 1'b1; lc_resp_valid_in = 1'b0;
      lc_resp_addr_in = '0;   lc_resp_data_in = '0;
      fill_ready_in = 1'b0;
      repeat (3) tick();
      chk("rst_miss_rdy", miss_ready_out, 0);
      chk("rst_valids", {lc_req_valid_out, cmpl_valid_out, fill_valid_out}, 0);
      chk("rst_addr", {lc_req_addr_out, fill_addr_out, cmpl_tag_out, cmpl_value_out}, 0);
      chk("rst_fill_data", fill_data_out, 0);
      rst_in = 1'b0;
      #1;
      chk("post_rst_rdy", miss_ready_out, 1);

      // single load, latency and install
      send_miss(19'h01040, 1'b0, 64'h0, 10'd5);
      chk("t1_req", {lc_req_valid_out, lc_req_addr_out}, {1'b1, 19'h01040});
      tick();
      chk("t1_req_done", lc_req_valid_out, 0);
      d = '0; d[63:0] = 64'hAA;
      send_fill(19'h01040, d);
      tick();
      chk("t1_lat1", cmpl_valid_out, 0);
      tick();
      exp_cmpl("t1_cmpl", 1'b0, 10'd5, 64'hAA);
      chk("t1_fill", {fill_valid_out, fill_addr_out}, {1'b1, 19'h01040});
      chk("t1_fill_data", fill_data_out, d);
      fill_ready_in = 1'b1;
      tick();
      fill_ready_in = 1'b0;
      chk("t1_fill_done", {fill_valid_out, cmpl_valid_out}, 0);

      // load/store/load merge on one block
      send_miss(19'h02000, 1'b0, 64'h0, 10'd1);
      chk("t2_req", {lc_req_valid_out, lc_req_addr_out}, {1'b1, 19'h02000});
      send_miss(19'h02008, 1'b1, 64'h55, 10'd2);
      chk("t2_one_req_a", lc_req_valid_out, 0);
      send_miss(19'h02008, 1'b0, 64'h0, 10'd3);
      chk("t2_one_req_b", lc_req_valid_out, 0);
      d = '0; d[63:0] = 64'h11; d[127:64] = 64'h22;
      send_fill(19'h02000, d);
      tick();
      tick();
      exp_cmpl("t2_c1", 1'b0, 10'd1, 64'h11);
      tick();
      exp_cmpl("t2_c2", 1'b1, 10'd2, 64'h55);
      tick();
      exp_cmpl("t2_c3", 1'b0, 10'd3, 64'h55);
      d[127:64] = 64'h55;
      chk("t2_fill_data", fill_data_out, d);
      chk("t2_fill_addr", {fill_valid_out, fill_addr_out}, {1'b1, 19'h02000});
      fill_ready_in = 1'b1;
      tick();

      // all entries busy, fifth miss waits for the first free entry
      send_miss(19'h03000, 1'b0, 64'h0, 10'd10);
      send_miss(19'h03040, 1'b0, 64'h0, 10'd11);
      send_miss(19'h03080, 1'b0, 64'h0, 10'd12);
      send_miss(19'h030C0, 1'b0, 64'h0, 10'd13);
      tick();
      chk("t3_all_issued", lc_req_valid_out, 0);
      miss_valid_in = 1'b1; miss_addr_in = 19'h04000; miss_we_in = 1'b0; miss_tag_in = 10'd14;
      #1;
      chk("t3_full_stall", miss_ready_out, 0);
      d = '0; d[63:0] = 64'h1234;
      send_fill(19'h03000, d);
      chk("t3_stall_ready", miss_ready_out, 0);
      tick();
      tick();
      exp_cmpl("t3_cmpl", 1'b0, 10'd10, 64'h1234);
      chk("t3_stall_drain", miss_ready_out, 0);
      tick();
      chk("t3_freed_rdy", miss_ready_out, 1);
      tick();
      miss_valid_in = 1'b0;
      chk("t3_new_req", {lc_req_valid_out, lc_req_addr_out}, {1'b1, 19'h04000});
      tick();
      n0 = n_cmpl;
      send_fill(19'h03040, '0);
      send_fill(19'h03080, '0);
      send_fill(19'h030C0, '0);
      send_fill(19'h04000, '0);
      repeat (30) tick();
      chk("t3_cleanup_cmpls", n_cmpl - n0, 4);

      // target limit on one entry
      for (int k = 0; k < 4; k++) send_miss(19'h05000 + 19'(8 * k), 1'b0, 64'h0, 10'(20 + k));
      miss_valid_in = 1'b1; miss_addr_in = 19'h05020; miss_we_in = 1'b0; miss_tag_in = 10'd24;
      #1;
      chk("t4_full_stall", miss_ready_out, 0);
      d = '0;
      d[63:0] = 64'h1; d[127:64] = 64'h2; d[191:128] = 64'h3; d[255:192] = 64'h4;
      send_fill(19'h05000, d);
      tick();
      for (int k = 0; k < 4; k++) begin
         tick();
         exp_cmpl("t4_cmpl", 1'b0, 10'(20 + k), 64'(k + 1));
      end
      chk("t4_stall_drain", {miss_ready_out, fill_valid_out}, {1'b0, 1'b1});
      tick();
      chk("t4_freed_rdy", miss_ready_out, 1);
      tick();
      miss_valid_in = 1'b0;
      chk("t4_new_req", {lc_req_valid_out, lc_req_addr_out}, {1'b1, 19'h05000});
      tick();
      d = '0; d[319:256] = 64'h77;
      send_fill(19'h05000, d);
      tick();
      tick();
      exp_cmpl("t4_late_tgt", 1'b0, 10'd24, 64'h77);
      repeat (4) tick();

      // issue held under backpressure
      fill_ready_in = 1'b0;
      lc_req_ready_in = 1'b0;
      send_miss(19'h06000, 1'b0, 64'h0, 10'd30);
      chk("t5_hold", {lc_req_valid_out, lc_req_addr_out}, {1'b1, 19'h06000});
      send_miss(19'h06008, 1'b0, 64'h0, 10'd31);
      chk("t5_hold", {lc_req_valid_out, lc_req_addr_out}, {1'b1, 19'h06000});
      send_miss(19'h06010, 1'b1, 64'hBEEF, 10'd32);
      for (int k = 0; k < 8; k++) begin
         chk("t5_hold", {lc_req_valid_out, lc_req_addr_out}, {1'b1, 19'h06000});
         tick();
      end
      lc_req_ready_in = 1'b1;
      chk("t5_hold_last", {lc_req_valid_out, lc_req_addr_out}, {1'b1, 19'h06000});
      tick();
      chk("t5_to_wait", lc_req_valid_out, 0);

      // reset in the middle of a drain
      d = '0; d[63:0] = 64'h600; d[127:64] = 64'h601;
      send_fill(19'h06000, d);
      tick();
      tick();
      exp_cmpl("t6_first", 1'b0, 10'd30, 64'h600);
      rst_in = 1'b1;
      #1;
      chk("t6_rst_rdy", miss_ready_out, 0);
      tick();
      chk("t6_rst_valids", {lc_req_valid_out, cmpl_valid_out, fill_valid_out}, 0);
      chk("t6_rst_data", {lc_req_addr_out, fill_addr_out, cmpl_tag_out, cmpl_value_out}, 0);
      chk("t6_rst_fill_data", fill_data_out, 0);
      n0 = n_cmpl;
      rst_in = 1'b0;
      send_fill(19'h06000, d);
      repeat (5) tick();
      chk("t6_late_fill_cmpl", n_cmpl - n0, 0);
      chk("t6_late_fill_inst", fill_valid_out, 0);
      send_miss(19'h06000, 1'b0, 64'h0, 10'd40);
      chk("t6_realloc", {lc_req_valid_out, lc_req_addr_out}, {1'b1, 19'h06000});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
